// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and line levels.
// PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: pulses bit_done on the last cycle of each bit.
// restart zeroes the count and takes priority over enable.
module uart_baud_cnt #(
    parameter int BAUD_DIV = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic enable,
    output logic bit_done
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt;

    assign bit_done = enable && !restart && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start, LSB-first data, parity, stop.
// Define UART_TX_PARITY_EN to add the parity_odd port and parity bit.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int BAUD_DIV  = 868,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_valid,
`ifdef UART_TX_PARITY_EN
    input  logic                 parity_odd,
`endif
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx
);

    localparam int IW = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("DATA_BITS must be 5..9");
    end
    if (BAUD_DIV < 2) begin : g_bad_baud
        $error("BAUD_DIV must be >= 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("STOP_BITS must be 1 or 2");
    end

    state_t               state, state_n;
    logic                 tx_q, tx_n;
    logic [DATA_BITS-1:0] sh_q, sh_n;
    logic [IW-1:0]        idx_q, idx_n;
    logic                 stp_q, stp_n;
    logic                 accept;
    logic                 bit_done;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_n;
`endif

    assign tx_ready = (state == IDLE);
    assign accept   = tx_ready && tx_valid;
    assign tx       = tx_q;

    uart_baud_cnt #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .restart (accept),
        .enable  (state != IDLE),
        .bit_done(bit_done)
    );

    always_comb begin
        state_n = state;
        tx_n    = tx_q;
        sh_n    = sh_q;
        idx_n   = idx_q;
        stp_n   = stp_q;
`ifdef UART_TX_PARITY_EN
        par_n   = par_q;
`endif
        unique case (state)
            IDLE: begin
                tx_n = IDLE_LEVEL;
                if (tx_valid) begin
                    state_n = START;
                    tx_n    = START_LEVEL;
                    sh_n    = tx_data;
                    idx_n   = '0;
                    stp_n   = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_n   = (^tx_data) ^ parity_odd;
`endif
                end
            end
            START: begin
                if (bit_done) begin
                    state_n = DATA;
                    tx_n    = sh_q[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (idx_q == LAST_IDX) begin
                        idx_n = '0;
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
                        tx_n    = par_q;
`else
                        state_n = STOP;
                        tx_n    = IDLE_LEVEL;
`endif
                    end else begin
                        idx_n = idx_q + 1'b1;
                        sh_n  = sh_q >> 1;
                        tx_n  = sh_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_n = STOP;
                    tx_n    = IDLE_LEVEL;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    if (stp_q == LAST_STOP) begin
                        state_n = IDLE;
                        stp_n   = 1'b0;
                    end else begin
                        stp_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            tx_q  <= IDLE_LEVEL;
            sh_q  <= '0;
            idx_q <= '0;
            stp_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q <= 1'b0;
`endif
        end else begin
            state <= state_n;
            tx_q  <= tx_n;
            sh_q  <= sh_n;
            idx_q <= idx_n;
            stp_q <= stp_n;
`ifdef UART_TX_PARITY_EN
            par_q <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: two configurations against a frame model.
// Honours UART_TX_PARITY_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_uart_tx_cfg;

`ifdef UART_TX_PARITY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif
    localparam int L0 = (10 + PEN) * 4;
    localparam int L1 = (10 + PEN) * 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0 = 1'b1, rst1 = 1'b1;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [7:0] d0 = '0;
    logic [6:0] d1 = '0;
    logic       po0 = 1'b0, po1 = 1'b0;
    logic       tx0, tx1, tx_ready0, tx_ready1;

    int checks = 0;
    int errors = 0;
    bit armed = 1'b0;

    uart_tx_cfg #(
        .DATA_BITS(8), .BAUD_DIV(4), .STOP_BITS(1)
    ) dut0 (
        .clk     (clk),
        .reset   (rst0),
        .tx_valid(v0),
`ifdef UART_TX_PARITY_EN
        .parity_odd(po0),
`endif
        .tx_data (d0),
        .tx_ready(tx_ready0),
        .tx      (tx0)
    );

    uart_tx_cfg #(
        .DATA_BITS(7), .BAUD_DIV(2), .STOP_BITS(2)
    ) dut1 (
        .clk     (clk),
        .reset   (rst1),
        .tx_valid(v1),
`ifdef UART_TX_PARITY_EN
        .parity_odd(po1),
`endif
        .tx_data (d1),
        .tx_ready(tx_ready1),
        .tx      (tx1)
    );

    // Frame model: a frame is a bit list, each bit lasting BD cycles.
    int          md  [2] = '{8, 7};
    int          ms  [2] = '{1, 2};
    int          mbd [2] = '{4, 2};
    bit          mbusy [2] = '{1'b0, 1'b0};
    int          mpos  [2];
    int          mlen  [2];
    logic [15:0] mbits [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [8:0] dd;
            logic       od;
            logic       r, v;
            r  = k ? rst1 : rst0;
            v  = k ? v1 : v0;
            dd = k ? {2'b0, d1} : {1'b0, d0};
            od = k ? po1 : po0;
            if (r) begin
                mbusy[k] = 1'b0;
            end else if (mbusy[k]) begin
                mpos[k]++;
                if (mpos[k] == mlen[k]) mbusy[k] = 1'b0;
            end else if (v) begin
                mbusy[k] = 1'b1;
                mpos[k]  = 0;
                mbits[k] = '1;
                mbits[k][0] = 1'b0;
                for (int i = 0; i < md[k]; i++)
                    mbits[k][1+i] = dd[i];
                if (PEN == 1)
                    mbits[k][1+md[k]] = (^dd) ^ od;
                mlen[k] = (1 + md[k] + PEN + ms[k]) * mbd[k];
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (armed) begin
            for (int k = 0; k < 2; k++) begin
                logic et, er, at, ar;
                et = mbusy[k] ? mbits[k][mpos[k] / mbd[k]] : 1'b1;
                er = !mbusy[k];
                at = k ? tx1 : tx0;
                ar = k ? tx_ready1 : tx_ready0;
                checks++;
                if (at !== et) begin
                    errors++;
                    $display("FAIL model_tx dut%0d t=%0t got %b want %b",
                             k, $time, at, et);
                end
                checks++;
                if (ar !== er) begin
                    errors++;
                    $display("FAIL model_ready dut%0d t=%0t got %b want %b",
                             k, $time, ar, er);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic logic rdy(input int k);
        return k ? tx_ready1 : tx_ready0;
    endfunction

    // Sends one frame, samples tx mid-bit, counts tx_ready-low cycles.
    task automatic frame(input int k, input logic [7:0] data,
                         input logic odd, input bit poke,
                         output int low, output logic [15:0] sb);
        logic s [1:256];
        int   bd;
        bd = k ? 2 : 4;
        @(negedge clk);
        chk($sformatf("ready_pre%0d", k), rdy(k), 1);
        if (k == 0) begin
            d0 = data; po0 = odd; v0 = 1'b1;
        end else begin
            d1 = data[6:0]; po1 = odd; v1 = 1'b1;
        end
        @(negedge clk);
        v0 = 1'b0;
        v1 = 1'b0;
        low = 0;
        while (rdy(k) == 1'b0 && low < 200) begin
            low++;
            s[low] = k ? tx1 : tx0;
            if (poke && low == 10) begin
                d0 = ~data; v0 = 1'b1;
            end
            if (poke && low == 11) v0 = 1'b0;
            @(negedge clk);
        end
        sb = '0;
        for (int j = 0; j < 16; j++)
            if (j * bd + 1 <= low) sb[j] = s[j * bd + 1];
    endtask

    initial begin : main
        int          low, hi;
        logic [15:0] sb, e, m;
        m = (PEN == 1) ? 16'h07FF : 16'h03FF;

        repeat (2) @(posedge clk);
        armed = 1'b1;
        @(negedge clk);
        chk("rst_tx", tx0, 1);
        chk("rst_ready", tx_ready0, 1);
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);

        frame(0, 8'hA5, 1'b0, 1'b0, low, sb);
        chk("a5_len", low, L0);
        e = (PEN == 1) ? 16'b101_0100_1010 : 16'b11_0100_1010;
        chk("a5_bits", int'(sb & m), int'(e));

        frame(0, 8'hA5, 1'b0, 1'b1, low, sb);
        chk("poke_len", low, L0);
        chk("poke_bits", int'(sb & m), int'(e));

        frame(0, 8'hA5, 1'b1, 1'b0, low, sb);
        e = (PEN == 1) ? 16'b111_0100_1010 : 16'b11_0100_1010;
        chk("a5odd_bits", int'(sb & m), int'(e));

        @(negedge clk);
        d0 = 8'h00;
        v0 = 1'b1;
        @(negedge clk);
        low = 0;
        while (tx_ready0 == 1'b0 && low < 200) begin
            low++;
            @(negedge clk);
        end
        chk("held_len0", low, L0);
        chk("gap_tx", tx0, 1);
        d0 = 8'hFF;
        hi = 0;
        while (tx_ready0 == 1'b1 && hi < 5) begin
            hi++;
            @(negedge clk);
        end
        v0 = 1'b0;
        chk("gap_ready_cycles", hi, 1);
        chk("second_start", tx0, 0);
        low = 0;
        while (tx_ready0 == 1'b0 && low < 200) begin
            low++;
            @(negedge clk);
        end
        chk("held_len1", low, L0);

        d0 = 8'h81;
        v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        repeat (12) @(negedge clk);
        rst0 = 1'b1;
        @(negedge clk);
        chk("abort_tx", tx0, 1);
        chk("abort_ready", tx_ready0, 1);
        rst0 = 1'b0;
        @(negedge clk);
        chk("no_resume_tx", tx0, 1);
        chk("no_resume_ready", tx_ready0, 1);

        frame(0, 8'h3C, 1'b0, 1'b0, low, sb);
        chk("3c_len", low, L0);
        e = (PEN == 1) ? 16'b100_0111_1000 : 16'b10_0111_1000;
        chk("3c_bits", int'(sb & m), int'(e));

        @(negedge clk);
        rst0 = 1'b1;
        v0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        v0 = 1'b0;
        chk("prio_ready", tx_ready0, 1);
        @(negedge clk);
        chk("prio_tx", tx0, 1);
        chk("prio_ready2", tx_ready0, 1);

        frame(1, 8'h55, 1'b0, 1'b0, low, sb);
        chk("d7_len", low, L1);
        e = (PEN == 1) ? 16'b110_1010_1010 : 16'b11_1010_1010;
        chk("d7_bits", int'(sb & m), int'(e));

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        errors++;
        $display("FAIL watchdog got timeout want finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal values are 5 to 9.
REQ-002 SHALL have parameter BAUD_DIV, default 868, meaning clk cycles per bit; legal values are 2 or more.
REQ-003 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values are 1 or 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 SHALL have port tx_valid, input, 1 bit: a frame request is present.
REQ-007 SHALL have port tx_data, input, DATA_BITS bits: the payload, sampled only on acceptance.
REQ-008 SHALL have port tx_ready, output, 1 bit: the block is idle and can accept a request.
REQ-009 SHALL have port tx, output, 1 bit: the serial line, idle high, driven from a register.
REQ-010 SHALL have port parity_odd, input, 1 bit, present only with UART_TX_PARITY_EN: 1 selects odd parity, 0 selects even parity.

Function
REQ-011 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-012 SHALL accept a request in a cycle where tx_valid and tx_ready are both 1, latching tx_data (and parity_odd when present) in that cycle.
REQ-013 SHALL drive tx low (start bit) in the first cycle after acceptance, which is a latency of 1.
REQ-014 SHALL hold each bit on tx for exactly BAUD_DIV cycles, timed by a bit counter that restarts at acceptance.
REQ-015 SHALL send the sequence START (0), then DATA_BITS data bits LSB first, then PARITY (only if enabled), then STOP_BITS stop bits (each 1), then return to IDLE.
REQ-016 SHALL make the frame length exactly (1 + DATA_BITS + P + STOP_BITS) x BAUD_DIV cycles, where P is 1 with parity enabled and 0 otherwise.
REQ-017 SHALL assert tx_ready only in IDLE; tx_valid is ignored and tx_data changes have no effect while the block is not in IDLE.
REQ-018 SHALL enter IDLE in the cycle after the last stop-bit cycle, so a held tx_valid is accepted in that cycle and tx_ready is high for that one cycle only.
REQ-019 SHALL keep tx at 1 in IDLE and keep tx_ready at 1 in IDLE, for any tx_valid value.
REQ-020 SHALL use a bit counter of width $clog2(BAUD_DIV), counting 0 to BAUD_DIV-1, with the bit index wrapping within 0 to DATA_BITS-1.
REQ-021 SHALL set the parity bit to the XOR of the latched data bits, inverted when odd parity is selected.

Reset
REQ-022 SHALL, while reset is 1 at a clk edge, set state to IDLE, tx to 1, tx_ready to 1 and all counters and the shift register to 0.
REQ-023 SHALL, on reset in mid-frame, abort the frame, drive tx to 1 in the next cycle, and not resume the frame.
REQ-024 SHALL give reset priority over a simultaneous tx_valid, so that no request is accepted in the reset cycle.

Configuration
REQ-025 SHALL, when the macro UART_TX_PARITY_EN is defined, include the parity_odd port and the PARITY state and send one parity bit after the data bits.
REQ-026 SHALL, when UART_TX_PARITY_EN is undefined, have no parity_odd port and no PARITY state, with STOP following DATA directly.

Structure
REQ-027 SHALL take the FSM state enum and the constants IDLE_LEVEL=1 and START_LEVEL=0 from a shared package, uart_pkg.
REQ-028 SHALL contain one sub-module, uart_baud_cnt, which has restart and enable inputs and a one-cycle bit_done pulse output every BAUD_DIV cycles.
REQ-029 SHALL check the parameter ranges at elaboration.

Verification
REQ-030 SHALL cover: DATA_BITS=8, BAUD_DIV=4, STOP_BITS=1, no parity, send 0xA5 -> tx is 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles, and tx_ready is low for 40 cycles.
REQ-031 SHALL cover: UART_TX_PARITY_EN defined, 0xA5 with parity_odd=0 -> parity bit 0; with parity_odd=1 -> parity bit 1; frame length is 44 cycles.
REQ-032 SHALL cover: tx_valid held high with 0x00 then 0xFF -> the second frame's start bit directly follows the first frame's stop bit, with tx_ready high for exactly 1 cycle between frames.
REQ-033 SHALL cover: reset asserted at cycle 13 of a frame -> tx is 1 in the next cycle, tx_ready is 1 after reset, and a new 0x3C frame sends correctly afterward.
REQ-034 SHALL cover: DATA_BITS=7, STOP_BITS=2, BAUD_DIV=2, send 0x55 -> 7 data bits alternating 1,0, two stop bits, and a frame length of 20 cycles.
REQ-035 SHALL cover: tx_data changed and tx_valid pulsed mid-frame -> the frame in progress is unchanged and the request is not accepted.
